complex_window_sum: RTL and testbench

//   Sliding-window accumulator for the complex products out of complex_mult.

---
 rtl/complex_window_sum.sv | 112 +++++++++++
 tb/tb_complex_window_sum.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/complex_window_sum.sv
// rtl/complex_window_sum.sv - sliding-window sum of the last 2**WINDOW_LOG2 complex product samples
//
// Purpose:
//   Keeps a running I/Q sum over the most recent N = 2**WINDOW_LOG2 accepted samples.
//   Each accepted sample is added, and the sample it displaces from the window is
//   subtracted. The result is full precision, so it matches an exact reference sum.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   enable         1 = accept strobes and act on clear; 0 = hold all state
//   clear          synchronous window flush; can coincide with an accept
//   sample_i/q     signed product components
//   input_strobe   sample valid
//   sum_i/q        signed windowed sums, OUT_WIDTH = IN_WIDTH + WINDOW_LOG2
//   output_strobe  one-cycle pulse marking an updated sum
//   window_full    set once N samples are accumulated since reset/clear
module complex_window_sum #(
    parameter int IN_WIDTH    = 32,
    parameter int WINDOW_LOG2 = 4,
    localparam int OUT_WIDTH  = IN_WIDTH + WINDOW_LOG2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic signed [IN_WIDTH-1:0]  sample_i,
    input  logic signed [IN_WIDTH-1:0]  sample_q,
    input  logic                        input_strobe,
    output logic signed [OUT_WIDTH-1:0] sum_i,
    output logic signed [OUT_WIDTH-1:0] sum_q,
    output logic                        output_strobe,
    output logic                        window_full
);

    localparam int N = 2 ** WINDOW_LOG2;
    localparam logic [WINDOW_LOG2:0] FULL_CNT = (WINDOW_LOG2 + 1)'(N);
    localparam logic [WINDOW_LOG2:0] ONE_CNT  = (WINDOW_LOG2 + 1)'(1);

    logic [WINDOW_LOG2-1:0]      wptr;
    logic [WINDOW_LOG2:0]        count;
    logic signed [IN_WIDTH-1:0]  mem_i [N];
    logic signed [IN_WIDTH-1:0]  mem_q [N];

    logic                        accept;
    logic [WINDOW_LOG2-1:0]      waddr;
    logic [WINDOW_LOG2:0]        count_next;
    logic signed [OUT_WIDTH-1:0] ext_i;
    logic signed [OUT_WIDTH-1:0] ext_q;
    logic signed [OUT_WIDTH-1:0] old_i;
    logic signed [OUT_WIDTH-1:0] old_q;

    always_comb begin
        accept     = enable & input_strobe;
        // A clear restarts the window, so the coincident sample lands in slot 0.
        waddr      = clear ? '0 : wptr;
        count_next = (count == FULL_CNT) ? FULL_CNT : count + 1'b1;
        ext_i      = {{WINDOW_LOG2{sample_i[IN_WIDTH-1]}}, sample_i};
        ext_q      = {{WINDOW_LOG2{sample_q[IN_WIDTH-1]}}, sample_q};
        old_i      = '0;
        old_q      = '0;
        // The slot about to be overwritten holds the oldest sample only once the
        // window is full; before that it was never written and must not be read.
        if (count == FULL_CNT) begin
            old_i = {{WINDOW_LOG2{mem_i[wptr][IN_WIDTH-1]}}, mem_i[wptr]};
            old_q = {{WINDOW_LOG2{mem_q[wptr][IN_WIDTH-1]}}, mem_q[wptr]};
        end
    end

    // Sample storage carries no reset; the fill count guards every read.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_i[waddr] <= sample_i;
            mem_q[waddr] <= sample_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_i         <= '0;
            sum_q         <= '0;
            output_strobe <= 1'b0;
            window_full   <= 1'b0;
            wptr          <= '0;
            count         <= '0;
        end else begin
            output_strobe <= accept;
            if (enable && clear) begin
                if (accept) begin
                    sum_i       <= ext_i;
                    sum_q       <= ext_q;
                    count       <= ONE_CNT;
                    wptr        <= WINDOW_LOG2'(1);
                    window_full <= (FULL_CNT == ONE_CNT);
                end else begin
                    sum_i       <= '0;
                    sum_q       <= '0;
                    count       <= '0;
                    wptr        <= '0;
                    window_full <= 1'b0;
                end
            end else if (accept) begin
                sum_i       <= sum_i + ext_i - old_i;
                sum_q       <= sum_q + ext_q - old_q;
                count       <= count_next;
                wptr        <= wptr + 1'b1;
                window_full <= (count_next == FULL_CNT);
            end
        end
    end

endmodule

// File: tb/tb_complex_window_sum.sv
// tb/tb_complex_window_sum.sv - self-checking bench for complex_window_sum
module tb_complex_window_sum;

    localparam int IW = 32;
    localparam int WL = 4;
    localparam int OW = IW + WL;
    localparam int NW = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 clear = 1'b0;
    logic signed [IW-1:0] sample_i = '0;
    logic signed [IW-1:0] sample_q = '0;
    logic                 input_strobe = 1'b0;
    logic signed [OW-1:0] sum_i;
    logic signed [OW-1:0] sum_q;
    logic                 output_strobe;
    logic                 window_full;

    int n_checks = 0;
    int n_fail   = 0;

    longint win_i[$];
    longint win_q[$];

    complex_window_sum #(.IN_WIDTH(IW), .WINDOW_LOG2(WL)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .clear(clear),
        .sample_i(sample_i),
        .sample_q(sample_q),
        .input_strobe(input_strobe),
        .sum_i(sum_i),
        .sum_q(sum_q),
        .output_strobe(output_strobe),
        .window_full(window_full)
    );

    always #5 clock = ~clock;

    function automatic longint qsum(input longint q[$]);
        longint s = 0;
        foreach (q[k]) s += q[k];
        return s;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_strobe);
        check({tag, ".sum_i"}, longint'(sum_i), qsum(win_i));
        check({tag, ".sum_q"}, longint'(sum_q), qsum(win_q));
        check({tag, ".output_strobe"}, longint'(output_strobe), longint'(exp_strobe));
        check({tag, ".window_full"}, longint'(window_full), longint'(win_i.size() == NW));
    endtask

    // One clock: drive inputs away from the edge, update the window model, check.
    task automatic step(input string tag, input bit en, input bit st, input bit cl,
                        input logic signed [IW-1:0] si, input logic signed [IW-1:0] sq);
        bit acc;
        enable       = en;
        input_strobe = st;
        clear        = cl;
        sample_i     = si;
        sample_q     = sq;
        @(posedge clock);
        #1;
        acc = en && st;
        if (en && cl) begin
            win_i.delete();
            win_q.delete();
        end
        if (acc) begin
            win_i.push_back(longint'(si));
            win_q.push_back(longint'(sq));
            if (win_i.size() > NW) begin
                void'(win_i.pop_front());
                void'(win_q.pop_front());
            end
        end
        check_outputs(tag, acc);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        check({tag, ".async_sum_i"}, longint'(sum_i), 0);
        check({tag, ".async_sum_q"}, longint'(sum_q), 0);
        check({tag, ".async_strobe"}, longint'(output_strobe), 0);
        check({tag, ".async_full"}, longint'(window_full), 0);
        win_i.delete();
        win_q.delete();
        @(posedge clock);
        #1;
        check_outputs({tag, ".held"}, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic signed [IW-1:0] vmax;
        logic signed [IW-1:0] vmin;
        vmax = 32'sh7FFF_FFFF;
        vmin = 32'sh8000_0000;

        @(posedge clock);
        @(posedge clock);
        #1;
        check_outputs("reset_state", 1'b0);
        reset = 1'b1;

        // Ramp up with constant samples.
        for (int k = 0; k < 16; k++) step("ramp", 1, 1, 0, 1, -1);
        // Drain with zeros through the pointer wrap.
        for (int k = 0; k < 16; k++) step("drain", 1, 1, 0, 0, 0);
        // Full-scale extremes.
        for (int k = 0; k < 40; k++) step("max", 1, 1, 0, vmax, vmax);
        for (int k = 0; k < 20; k++) step("min", 1, 1, 0, vmin, vmin);

        // Random gaps with an enable-low window where strobes and clear are ignored.
        for (int k = 0; k < 60; k++) begin
            bit en;
            bit cl;
            en = !(k >= 25 && k < 30);
            cl = !en && (k == 27);
            step("rand_gap", en, 1'($urandom_range(0, 1)) || !en, cl,
                 $signed($urandom), $signed($urandom));
        end

        // Plain clear without an accept, then refill and clear with accept.
        step("clear_only", 1, 0, 1, 0, 0);
        for (int k = 0; k < 18; k++) step("refill", 1, 1, 0, $signed($urandom), $signed($urandom));
        step("clear_acc", 1, 1, 1, 7, 3);
        check("clear_acc.sum_i_is_7", longint'(sum_i), 7);
        check("clear_acc.sum_q_is_3", longint'(sum_q), 3);
        for (int k = 0; k < 20; k++) step("post_clear", 1, 1, 0, $signed($urandom), $signed($urandom));

        // Asynchronous reset mid-stream, then an empty-window restart.
        do_reset("mid_reset");
        for (int k = 0; k < 24; k++) begin
            step("post_reset", 1, 1'($urandom_range(0, 3) != 0), 0,
                 $signed($urandom), $signed($urandom));
        end
        step("idle", 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
